mac_req_arbiter: RTL
====================

Name: mac_req_arbiter

Overview:
Round-robin controller that shares one 3-beat multiply-add datapath among NREQ requesters. The datapath computes data_out = a*b+c, where a, b and c are three consecutive data_in beats qualified by validi. Each requester presents an (a, b, c) triple. The arbiter grants one requester, streams the three beats into the datapath, captures the result on valido, and returns it to the granted requester over a valid/ready response channel.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 32, datapath word width
TIMEOUT, 4, max WAIT cycles for dp_valido before error response (>=1)

Ports:
clk  in  1  clock, all logic on posedge
rst_  in  1  asynchronous reset, active-low
req_valid  in  NREQ  requester i has a triple pending
req_a  in  NREQ*DW  packed operand a per requester (slice i = bits i*DW +: DW)
req_b  in  NREQ*DW  packed operand b
req_c  in  NREQ*DW  packed operand c
req_ready  out  NREQ  one-cycle one-hot accept pulse; triple latched this cycle
rsp_valid  out  NREQ  one-hot response valid to granted requester
rsp_ready  in  NREQ  response accept per requester
rsp_data  out  DW  result (shared bus)
rsp_err  out  1  qualifies rsp_valid: 1 = datapath timeout, rsp_data=0
dp_rst  out  1  active-high datapath reset
dp_validi  out  1  datapath beat valid
dp_data_in  out  DW  datapath beat data
dp_valido  in  1  datapath result valid
dp_data_out  in  DW  datapath result
dp_err  out  1  sticky: dp_valido seen outside WAIT

Behaviour:
- Reset (rst_=0, async): state=IDLE; req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, dp_validi=0, dp_data_in=0, dp_err=0, dp_rst=1; last_grant=NREQ-1, so requester 0 has first priority.
- dp_rst is registered. It stays 1 for exactly one clk after rst_ deasserts, then 0.
- FSM states: IDLE, BEAT_A, BEAT_B, BEAT_C, WAIT, RESP.
- IDLE: if any req_valid, pick g = first set bit searching from last_grant+1 upward with wrap. Pulse req_ready[g], latch a/b/c and g, go to BEAT_A. Otherwise stay. The grant decision is combinational on req_valid within this cycle.
- BEAT_A/B/C: dp_validi=1, dp_data_in = a, b, c respectively. Exactly 3 consecutive beats, then WAIT.
- WAIT: dp_validi=0, dp_data_in=0, wait counter starts at 1.
  - If dp_valido=1: capture dp_data_out, rsp_err=0, go to RESP.
  - Else if counter==TIMEOUT: result=0, rsp_err=1, go to RESP.
  - Otherwise increment the counter.
  - The nominal datapath asserts valido in the first WAIT cycle.
- RESP: rsp_valid[g]=1. rsp_data and rsp_err are held stable until rsp_ready[g]=1. On that handshake: last_grant=g, go to IDLE. rsp_ready of other requesters is ignored.
- Nominal latency: accept at cycle T; beats at T+1..T+3; valido at T+4; rsp_valid at T+5.
- dp_validi is low for at least 3 cycles between bursts (WAIT, RESP, IDLE). The datapath therefore never sees more than 3 consecutive beats, and overlapping windows cannot produce a spurious valido.
- dp_valido=1 in any state other than WAIT sets dp_err. dp_err clears only on reset. The FSM is unaffected.
- req_valid dropping after acceptance has no effect; the latched triple is used.
- Arithmetic is done entirely by the datapath. Results are mod 2^DW; the controller neither checks nor extends them.
- Reset mid-operation aborts the burst: no response is issued and round-robin priority returns to requester 0.

Test Plan:
1. Single request: req_valid=0001, a=3, b=4, c=5 -> req_ready[0] at T; dp_data_in 3,4,5 with dp_validi=1 on T+1..T+3; rsp_valid[0] at T+5 with rsp_data=17, rsp_err=0.
2. Round robin: req_valid=1111 held, rsp_ready=1111 -> grant order 0,1,2,3,0; each burst 6 cycles; dp_validi never high for more than 3 consecutive cycles.
3. Backpressure: rsp_ready[1]=0 for 5 cycles during RESP -> rsp_valid[1], rsp_data, rsp_err stable; no req_ready pulse; dp_validi=0 throughout.
4. Wrap: a=32'hFFFF_FFFF, b=2, c=3 -> rsp_data=32'h0000_0001.
5. Timeout: datapath model never asserts valido, TIMEOUT=4 -> 4 WAIT cycles, then rsp_valid with rsp_err=1, rsp_data=0; the next request is then served normally.
6. Reset/spurious: force dp_valido=1 in IDLE -> dp_err=1 and sticky. Assert rst_=0 during BEAT_B -> all outputs at reset values immediately, dp_rst=1; dp_rst drops one clk after release; the next grant goes to requester 0.

Source files
------------

// File: rtl/mac_req_arbiter.sv
// Round-robin arbiter sharing one 3-beat a*b+c datapath among NREQ requesters.
// Accept at T; beats T+1..T+3; response at T+5. The response is held until rsp_ready[grant].
module mac_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 32,
  parameter int TIMEOUT = 4
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_a,
  input  logic [NREQ*DW-1:0] req_b,
  input  logic [NREQ*DW-1:0] req_c,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  input  logic [NREQ-1:0]    rsp_ready,
  output logic [DW-1:0]      rsp_data,
  output logic               rsp_err,
  output logic               dp_rst,
  output logic               dp_validi,
  output logic [DW-1:0]      dp_data_in,
  input  logic               dp_valido,
  input  logic [DW-1:0]      dp_data_out,
  output logic               dp_err
);

  localparam int GW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_BEAT_A, S_BEAT_B, S_BEAT_C, S_WAIT, S_RESP
  } state_t;

  state_t          r_state, w_next;
  logic [GW-1:0]   r_last_grant, r_grant, w_gnt_idx;
  logic            w_gnt_vld, w_accept, w_rsp_hs;
  logic [DW-1:0]   r_a, r_b, r_c, r_rsp_data;
  logic [CW-1:0]   r_cnt;
  logic            r_rsp_err, r_dp_err, r_dp_rst;

  // Search starts just after the last served requester, wrapping around.
  always_comb begin : p_grant
    logic [GW-1:0] cand;
    cand      = '0;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = GW'((int'(r_last_grant) + k) % NREQ);
      if (!w_gnt_vld && req_valid[cand]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = cand;
      end
    end
  end

  // No grant while the datapath is still held in reset.
  assign w_accept = (r_state == S_IDLE) && w_gnt_vld && !r_dp_rst;
  assign w_rsp_hs = (r_state == S_RESP) && rsp_ready[r_grant];

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    req_ready  = '0;
    rsp_valid  = '0;
    dp_validi  = 1'b0;
    dp_data_in = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          req_ready = NREQ'(1) << w_gnt_idx;
          w_next    = S_BEAT_A;
        end
      end
      S_BEAT_A: begin
        dp_validi  = 1'b1;
        dp_data_in = r_a;
        w_next     = S_BEAT_B;
      end
      S_BEAT_B: begin
        dp_validi  = 1'b1;
        dp_data_in = r_b;
        w_next     = S_BEAT_C;
      end
      S_BEAT_C: begin
        dp_validi  = 1'b1;
        dp_data_in = r_c;
        w_next     = S_WAIT;
      end
      S_WAIT: begin
        if (dp_valido || (r_cnt == CW'(TIMEOUT))) w_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid = NREQ'(1) << r_grant;
        if (w_rsp_hs) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_last_grant <= GW'(NREQ - 1);
      r_grant      <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_c          <= '0;
      r_cnt        <= '0;
      r_rsp_data   <= '0;
      r_rsp_err    <= 1'b0;
      r_dp_err     <= 1'b0;
      r_dp_rst     <= 1'b1;
    end else begin
      r_dp_rst <= 1'b0;
      if (dp_valido && (r_state != S_WAIT)) r_dp_err <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_grant <= w_gnt_idx;
            r_a     <= req_a[w_gnt_idx*DW +: DW];
            r_b     <= req_b[w_gnt_idx*DW +: DW];
            r_c     <= req_c[w_gnt_idx*DW +: DW];
          end
        end
        S_BEAT_C: r_cnt <= CW'(1);
        S_WAIT: begin
          if (dp_valido) begin
            r_rsp_data <= dp_data_out;
            r_rsp_err  <= 1'b0;
          end else if (r_cnt == CW'(TIMEOUT)) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: if (w_rsp_hs) r_last_grant <= r_grant;
        default: ;
      endcase
    end
  end

  assign rsp_data = r_rsp_data;
  assign rsp_err  = r_rsp_err;
  assign dp_err   = r_dp_err;
  assign dp_rst   = r_dp_rst;

endmodule
